// File: rtl/counter_updn_if.sv
// Control and status bundle for counter_updn.
// The master drives the controls, and the slave (the counter) drives the count and its flags.
interface counter_updn_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned WRAP_W = 16
);
    logic              clear;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              en;
    logic              up;
    logic [WIDTH-1:0]  Q;
    logic              at_max;
    logic              at_zero;
    logic              wrap;
    logic              sat_hit;
    logic [WRAP_W-1:0] wrap_count;

    modport master (
        output clear, load, load_val, en, up,
        input  Q, at_max, at_zero, wrap, sat_hit, wrap_count
    );

    modport slave (
        input  clear, load, load_val, en, up,
        output Q, at_max, at_zero, wrap, sat_hit, wrap_count
    );
endinterface

// File: rtl/counter_updn.sv
// Up/down counter that counts from 0 to MAX_COUNT. At a boundary it either wraps or saturates.
// It also counts wrap events, and that wrap counter saturates at its maximum value.
module counter_updn #(
    parameter int unsigned      WIDTH     = 8,
    parameter longint unsigned  MAX_COUNT = 128,
    parameter int unsigned      SATURATE  = 0,
    parameter int unsigned      WRAP_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    counter_updn_if.slave     bus
);
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter_updn: WIDTH %0d outside 1..32", WIDTH);
    end
    if (MAX_COUNT < 64'd1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("counter_updn: MAX_COUNT %0d outside 1..2^WIDTH-1", MAX_COUNT);
    end

    localparam logic [WIDTH-1:0]  MAX_Q  = WIDTH'(MAX_COUNT);
    localparam logic [WRAP_W-1:0] WC_TOP = '1;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_STEP,
        OP_WRAP,
        OP_BLOCK
    } op_t;

    op_t              op;
    logic             at_bound;
    logic [WIDTH-1:0] load_clamped;

    assign bus.at_max  = (bus.Q == MAX_Q);
    assign bus.at_zero = (bus.Q == '0);

    // Priority is resolved here, so the register block only has to act on one decoded operation.
    always_comb begin
        op           = OP_HOLD;
        at_bound     = bus.up ? (bus.Q == MAX_Q) : (bus.Q == '0);
        load_clamped = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
        if (bus.clear) begin
            op = OP_CLEAR;
        end else if (bus.load) begin
            op = OP_LOAD;
        end else if (bus.en) begin
            if (!at_bound)
                op = OP_STEP;
            else if (SATURATE != 0)
                op = OP_BLOCK;
            else
                op = OP_WRAP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Q          <= '0;
            bus.wrap       <= 1'b0;
            bus.sat_hit    <= 1'b0;
            bus.wrap_count <= '0;
        end else begin
            bus.wrap    <= 1'b0;
            bus.sat_hit <= 1'b0;
            unique case (op)
                OP_CLEAR: begin
                    bus.Q          <= '0;
                    bus.wrap_count <= '0;
                end
                OP_LOAD: bus.Q <= load_clamped;
                OP_STEP: bus.Q <= bus.up ? bus.Q + WIDTH'(1) : bus.Q - WIDTH'(1);
                OP_WRAP: begin
                    bus.Q    <= bus.up ? '0 : MAX_Q;
                    bus.wrap <= 1'b1;
                    if (bus.wrap_count != WC_TOP)
                        bus.wrap_count <= bus.wrap_count + WRAP_W'(1);
                end
                OP_BLOCK: bus.sat_hit <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule
